// File: rtl/systolic_feeder.sv
// Edge feeder for an NxN output-stationary MAC array: skews activation/weight
// lanes, clears the array before each tile, flushes zeros after the last beat.
module systolic_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned DW = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N*DW-1:0]   a_vec_i,
  input  logic [N*DW-1:0]   w_vec_i,
  output logic [N*DW-1:0]   a_out_o,
  output logic [N*DW-1:0]   w_out_o,
  output logic              arr_clr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned FW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(K - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(2 * N - 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            in_ready_q, arr_clr_q, busy_q, done_q;
  logic            accept;
  logic [N*DW-1:0] a_inj, w_inj;

  // Next-state, counters and beat acceptance
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (in_valid_i) begin
          accept = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == LAST_FLUSH) state_d = ST_DONE;
        else flush_cnt_d = flush_cnt_q + FW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      arr_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      in_ready_q  <= (state_d == ST_STREAM);
      arr_clr_q   <= (state_d == ST_CLEAR);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Bubbles and flush cycles inject zeros into every lane
  assign a_inj = accept ? a_vec_i : '0;
  assign w_inj = accept ? w_vec_i : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_o_q, w_o_q;

    if (i == 0) begin : g_direct
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          a_o_q <= '0;
          w_o_q <= '0;
        end else begin
          a_o_q <= a_inj[DW-1:0];
          w_o_q <= w_inj[DW-1:0];
        end
      end
    end else begin : g_delay
      // Lane i: i-stage delay line ahead of the output register
      logic [DW-1:0] a_dl_q [i];
      logic [DW-1:0] w_dl_q [i];

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          for (int s = 0; s < i; s++) begin
            a_dl_q[s] <= '0;
            w_dl_q[s] <= '0;
          end
          a_o_q <= '0;
          w_o_q <= '0;
        end else begin
          a_dl_q[0] <= a_inj[i*DW +: DW];
          w_dl_q[0] <= w_inj[i*DW +: DW];
          for (int s = 1; s < i; s++) begin
            a_dl_q[s] <= a_dl_q[s-1];
            w_dl_q[s] <= w_dl_q[s-1];
          end
          a_o_q <= a_dl_q[i-1];
          w_o_q <= w_dl_q[i-1];
        end
      end
    end

    assign a_out_o[i*DW +: DW] = a_o_q;
    assign w_out_o[i*DW +: DW] = w_o_q;
  end

  assign in_ready_o = in_ready_q;
  assign arr_clr_o  = arr_clr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle-accurate lane timing from accepted beats plus
// a behavioural MAC-array model fed by the observed edges.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int NB = 2;
  localparam int KB = 1;
  localparam int AW = N * DW;
  localparam int BW = NB * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, valid_a, ready_a, clr_a, busy_a, done_a;
  logic [AW-1:0] avec_a, wvec_a, aout_a, wout_a;
  logic          start_b, valid_b, ready_b, clr_b, busy_b, done_b;
  logic [BW-1:0] avec_b, wvec_b, aout_b, wout_b;

  systolic_feeder #(.N(N), .K(K), .DW(DW)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .in_valid_i(valid_a),
    .in_ready_o(ready_a), .a_vec_i(avec_a), .w_vec_i(wvec_a),
    .a_out_o(aout_a), .w_out_o(wout_a), .arr_clr_o(clr_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  systolic_feeder #(.N(NB), .K(KB), .DW(DW)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .in_valid_i(valid_b),
    .in_ready_o(ready_b), .a_vec_i(avec_b), .w_vec_i(wvec_b),
    .a_out_o(aout_b), .w_out_o(wout_b), .arr_clr_o(clr_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] beat_a [K][N];
  logic [DW-1:0] beat_w [K][N];
  logic [DW-1:0] ha [128][N];
  logic [DW-1:0] hw [128][N];
  int            tacc [K];
  int            dn_nostall;

  task automatic fill_random();
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        beat_a[k][i] = DW'($urandom);
        beat_w[k][i] = DW'($urandom);
      end
  endtask

  // Drives one tile on dut_a (cycle 0 = start high in IDLE) and checks every cycle.
  // vmode: 0 always valid, 1 alternate cycles, 2 random. noise: junk start/valid
  // where they must be ignored. b2b: hold start through DONE. abort_off: rst low at T+off.
  task automatic run_tile(input int vmode, input bit noise, input bit b2b,
                          input int abort_off, output int done_cyc);
    int c, nacc, t_last, acc, refsum;
    bit in_stream, v, aborted, exp_busy, exp_done;
    logic [AW-1:0] ea, ew;
    c = 0; nacc = 0; t_last = -1; aborted = 1'b0; done_cyc = -1;
    @(posedge clk); #1;
    while (1) begin
      in_stream = (c >= 2) && (nacc < K);
      start_a = 1'b0;
      if (c == 0) start_a = 1'b1;
      else if (t_last >= 0 && c == t_last + 2*N) start_a = b2b;
      else if (noise && c >= 2 && (t_last < 0 || c < t_last + 2*N)) start_a = 1'($urandom);
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((c - 2) % 2 == 0);
        default: v = 1'($urandom);
      endcase
      if (!in_stream) v = noise ? 1'($urandom) : 1'b0;
      valid_a = v;
      avec_a  = AW'($urandom);
      wvec_a  = AW'($urandom);
      if (in_stream && v) begin
        for (int i = 0; i < N; i++) begin
          avec_a[i*DW +: DW] = beat_a[nacc][i];
          wvec_a[i*DW +: DW] = beat_w[nacc][i];
        end
      end
      if (abort_off >= 0 && t_last >= 0 && c == t_last + abort_off) begin
        rst = 1'b0;
        aborted = 1'b1;
      end
      ea = '0; ew = '0;
      for (int k = 0; k < nacc; k++)
        for (int i = 0; i < N; i++)
          if (tacc[k] + 1 + i == c) begin
            ea[i*DW +: DW] = beat_a[k][i];
            ew[i*DW +: DW] = beat_w[k][i];
          end
      if (in_stream && v) begin
        tacc[nacc] = c;
        nacc++;
        if (nacc == K) t_last = c;
      end
      exp_busy = (c >= 1) && (t_last < 0 || c <= t_last + 2*N);
      exp_done = (t_last >= 0) && (c == t_last + 2*N);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ha[c][i] = aout_a[i*DW +: DW];
        hw[c][i] = wout_a[i*DW +: DW];
      end
      total++; if (aout_a !== ea) begin bad++; $display("FAIL a_out c=%0d got=%h exp=%h", c, aout_a, ea); end
      total++; if (wout_a !== ew) begin bad++; $display("FAIL w_out c=%0d got=%h exp=%h", c, wout_a, ew); end
      total++; if (ready_a !== in_stream) begin bad++; $display("FAIL in_ready c=%0d got=%b exp=%b", c, ready_a, in_stream); end
      total++; if (clr_a !== (c == 1)) begin bad++; $display("FAIL arr_clr c=%0d got=%b exp=%b", c, clr_a, (c == 1)); end
      total++; if (busy_a !== exp_busy) begin bad++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy_a, exp_busy); end
      total++; if (done_a !== exp_done) begin bad++; $display("FAIL done c=%0d got=%b exp=%b", c, done_a, exp_done); end
      if (done_a === 1'b1 && done_cyc < 0) done_cyc = c;
      if (exp_done) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc = 0; refsum = 0;
            for (int cc = 2; cc < c; cc++)
              if (cc - j >= 0 && cc - i >= 0)
                acc += int'(ha[cc-j][i]) * int'(hw[cc-i][j]);
            for (int k = 0; k < K; k++)
              refsum += int'(beat_a[k][i]) * int'(beat_w[k][j]);
            total++;
            if (acc !== refsum) begin
              bad++; $display("FAIL pe_sum(%0d,%0d) got=%0d exp=%0d", i, j, acc, refsum);
            end
          end
      end
      if (aborted) break;
      if (t_last >= 0 && c >= (b2b ? t_last + 2*N : t_last + 2*N + 1)) break;
      if (c >= 100) begin
        total++; bad++; $display("FAIL tile_timeout got=%0d beats exp=%0d", nacc, K);
        break;
      end
      c++;
      @(posedge clk); #1;
    end
    if (aborted) begin
      for (int n = 0; n < 6; n++) begin
        @(posedge clk); #1;
        rst = 1'b1; start_a = 1'b0; valid_a = 1'($urandom);
        @(negedge clk);
        total++;
        if ({aout_a, wout_a, ready_a, clr_a, busy_a, done_a} !== '0) begin
          bad++; $display("FAIL post_abort n=%0d got=%h/%h r%b c%b b%b d%b exp=0", n,
                          aout_a, wout_a, ready_a, clr_a, busy_a, done_a);
        end
      end
    end
    start_a = 1'b0;
    valid_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b1; valid_a = 1'b1; start_b = 1'b1; valid_b = 1'b1;
    avec_a = AW'($urandom); wvec_a = AW'($urandom);
    avec_b = BW'($urandom); wvec_b = BW'($urandom);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({aout_a, wout_a, ready_a, clr_a, busy_a, done_a} !== '0) begin
        bad++; $display("FAIL reset_a n=%0d got=%h/%h r%b c%b b%b d%b exp=0", n,
                        aout_a, wout_a, ready_a, clr_a, busy_a, done_a);
      end
      total++;
      if ({aout_b, wout_b, ready_b, clr_b, busy_b, done_b} !== '0) begin
        bad++; $display("FAIL reset_b n=%0d got=%h/%h r%b c%b b%b d%b exp=0", n,
                        aout_b, wout_b, ready_b, clr_b, busy_b, done_b);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
  endtask

  task automatic test_skew();
    int dn;
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        beat_a[k][i] = DW'(16*k + i);
        beat_w[k][i] = DW'(16*k + 8 + i);
      end
    run_tile(0, 1'b0, 1'b0, -1, dn);
    dn_nostall = dn;
    total++;
    if (dn !== K + 2*N + 1) begin bad++; $display("FAIL skew_done_cycle got=%0d exp=%0d", dn, K + 2*N + 1); end
  endtask

  task automatic test_stalls();
    int dn;
    run_tile(1, 1'b0, 1'b0, -1, dn);
    total++;
    if (dn !== dn_nostall + 3) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=%0d", dn, dn_nostall + 3); end
  endtask

  task automatic test_k1();
    logic [DW-1:0] hba [8][NB];
    logic [DW-1:0] hbw [8][NB];
    int exp_pe [NB][NB];
    logic [BW-1:0] ea, ew;
    int acc;
    exp_pe[0][0] = 21; exp_pe[0][1] = 6; exp_pe[1][0] = 35; exp_pe[1][1] = 10;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      start_b = (c == 0);
      valid_b = (c == 2) ? 1'b1 : 1'($urandom);
      avec_b  = (c == 2) ? {8'd5, 8'd3} : BW'($urandom);
      wvec_b  = (c == 2) ? {8'd2, 8'd7} : BW'($urandom);
      ea = '0; ew = '0;
      if (c == 3) begin ea[DW-1:0] = 8'd3; ew[DW-1:0] = 8'd7; end
      if (c == 4) begin ea[BW-1:DW] = 8'd5; ew[BW-1:DW] = 8'd2; end
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        hba[c][i] = aout_b[i*DW +: DW];
        hbw[c][i] = wout_b[i*DW +: DW];
      end
      total++; if (aout_b !== ea) begin bad++; $display("FAIL k1_a_out c=%0d got=%h exp=%h", c, aout_b, ea); end
      total++; if (wout_b !== ew) begin bad++; $display("FAIL k1_w_out c=%0d got=%h exp=%h", c, wout_b, ew); end
      total++; if (ready_b !== (c == 2)) begin bad++; $display("FAIL k1_in_ready c=%0d got=%b exp=%b", c, ready_b, (c == 2)); end
      total++; if (clr_b !== (c == 1)) begin bad++; $display("FAIL k1_arr_clr c=%0d got=%b exp=%b", c, clr_b, (c == 1)); end
      total++; if (busy_b !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL k1_busy c=%0d got=%b exp=%b", c, busy_b, (c >= 1 && c <= 6)); end
      total++; if (done_b !== (c == 6)) begin bad++; $display("FAIL k1_done c=%0d got=%b exp=%b", c, done_b, (c == 6)); end
      if (c == 6) begin
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < NB; j++) begin
            acc = 0;
            for (int cc = 2; cc < 6; cc++)
              if (cc - j >= 0 && cc - i >= 0)
                acc += int'(hba[cc-j][i]) * int'(hbw[cc-i][j]);
            total++;
            if (acc !== exp_pe[i][j]) begin
              bad++; $display("FAIL k1_pe_sum(%0d,%0d) got=%0d exp=%0d", i, j, acc, exp_pe[i][j]);
            end
          end
      end
      @(posedge clk); #1;
    end
    start_b = 1'b0; valid_b = 1'b0;
  endtask

  task automatic test_abort();
    int dn;
    fill_random();
    run_tile(2, 1'b0, 1'b0, 2, dn);
    total++;
    if (dn !== -1) begin bad++; $display("FAIL abort_done got=%0d exp=-1", dn); end
    fill_random();
    run_tile(2, 1'b0, 1'b0, -1, dn);
  endtask

  task automatic test_ignored();
    int dn;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0; valid_a = 1'b1;
      avec_a = AW'($urandom); wvec_a = AW'($urandom);
      @(negedge clk);
      total++;
      if ({aout_a, wout_a, ready_a, clr_a, busy_a, done_a} !== '0) begin
        bad++; $display("FAIL idle_valid n=%0d got=%h/%h r%b c%b b%b d%b exp=0", n,
                        aout_a, wout_a, ready_a, clr_a, busy_a, done_a);
      end
    end
    valid_a = 1'b0;
    fill_random();
    run_tile(0, 1'b1, 1'b0, -1, dn);
    fill_random();
    run_tile(2, 1'b1, 1'b0, -1, dn);
  endtask

  task automatic test_back_to_back();
    int dn;
    fill_random();
    run_tile(0, 1'b0, 1'b1, -1, dn);
    fill_random();
    run_tile(2, 1'b0, 1'b0, -1, dn);
  endtask

  task automatic test_random();
    int dn;
    for (int n = 0; n < 6; n++) begin
      fill_random();
      run_tile($urandom_range(0, 2), 1'($urandom), 1'b0, -1, dn);
    end
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; valid_a = 1'b0; avec_a = '0; wvec_a = '0;
    start_b = 1'b0; valid_b = 1'b0; avec_b = '0; wvec_b = '0;
    test_reset();
    test_skew();
    test_stalls();
    test_k1();
    test_abort();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Edge feeder for the N×N output-stationary MAC array. It accepts one reduction step per beat: an N-wide activation column and an N-wide weight row. It skews lane i by i cycles and drives the array's west (activation) and north (weight) edges. After the last beat it streams zeros until every PE has accumulated its final product, then pulses `done`. It also issues the one-cycle array clear that zeroes the PE accumulators before each tile.

## Interface
- `N`, 4: array dimension (rows = columns = lanes), 2..16
- `K`, 4: reduction depth, i.e. beats per tile, 1..255
- `DW`, 8: operand width per lane
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-low reset
- `start` input 1: begin a tile; sampled only in IDLE
- `in_valid` input 1: `a_vec`/`w_vec` hold a valid beat
- `in_ready` output 1: feeder accepts a beat this cycle
- `a_vec` input N*DW: activation column; lane i = bits [i*DW +: DW] → array row i
- `w_vec` input N*DW: weight row; lane j → array column j
- `a_out` output N*DW: registered, skewed west-edge activations
- `w_out` output N*DW: registered, skewed north-edge weights
- `arr_clr` output 1: active-high one-cycle clear to all PEs
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle pulse; all PE sums final

## Operation
- Reset (`rst`=0 at an edge) forces:
  - state IDLE
  - all delay-line registers and beat counter cleared
  - `a_out`=0, `w_out`=0, `in_ready`=0, `arr_clr`=0, `busy`=0, `done`=0
- States: IDLE → CLEAR → STREAM → FLUSH → DONE → IDLE.
- **IDLE:** `start`=1 → CLEAR.
- **CLEAR:** one cycle with `arr_clr`=1 → STREAM. Counter is cleared.
- **STREAM:** `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`, and the counter increments.
  - Accepting the K-th beat → FLUSH.
  - A cycle with `in_valid`=0 injects an all-zero bubble into every lane. Both operands are zero and skew identically, so PE alignment is preserved.
- **FLUSH:** exactly 2N-1 cycles with `in_ready`=0. Zeros are injected; a flush counter tracks the length. Then → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Skew:** lane i has an i-stage zero-initialised delay line followed by the output register. The same structure is used for `a` and `w`.
- **Data path:** pass-through only, no arithmetic. Widths are preserved. Lanes not carrying an accepted beat are exactly 0.
- **Edge cases:**
  - `start` outside IDLE is ignored.
  - `in_valid` outside STREAM is ignored, and nothing is consumed.
  - `rst`=0 mid-tile aborts immediately:
    - no `done` pulse
    - partial data is discarded
    - outputs are zero on the next cycle
  - `start` held high across DONE begins a new tile the cycle after returning to IDLE.
  - K=1: a single beat goes straight to FLUSH.

## Timing
- `start` sampled high at cycle 0:
  - cycle 1: CLEAR, `arr_clr`=1
  - cycle 2: first cycle with `in_ready`=1
- Beat accepted at cycle t:
  - `a_out`/`w_out` lane i carries it at cycle t+1+i
  - PE(i,j) sees it at cycle t+1+i+j
- Last beat accepted at cycle T:
  - FLUSH occupies T+1..T+2N-1
  - `done`=1 at T+2N
  - `busy` falls at T+2N+1
- At the `done` cycle, all PE accumulators (including PE(N-1,N-1)) hold the final sum.
- Zero-stall tile length from `start` to `done` is K+2N+1 cycles.
- Outputs are registered; no combinational path from inputs to `a_out`/`w_out`. `in_ready` depends on state only.

## Test plan
- **Reset/idle:** hold `rst`=0 for 3 cycles with `start`=1 and `in_valid`=1 → all outputs 0, `busy`=0. After release, `start` → `arr_clr` high for exactly one cycle at cycle 1.
- **Skew, N=4 K=4, no stalls:**
  - Stimulus: beats k=0..3 with `a_vec` lane i = 16k+i and `w_vec` lane j = 16k+8+j.
  - Response: `a_out` lane i equals 16k+i exactly at cycle t_k+1+i, and 0 otherwise.
  - Response: `done` pulses at T+8.
  - Response: the MAC-array model gives s(i,j) = Σ_k a·w with no overflow check.
- **Stalls:** same data with `in_valid` low on alternate cycles → zero bubbles appear in all lanes simultaneously, array sums match the no-stall run, and `done` comes 3 cycles later.
- **K=1, N=2:** single beat a=(3,5), w=(7,2) → FLUSH lasts 3 cycles, `done` at T+4, products 21/6/35/10 in the array.
- **Abort:** pull `rst`=0 during FLUSH → no `done`. The next tile (a new `start`) produces correct sums with no residue from the aborted tile.
- **Ignored inputs:** `start` pulses during STREAM and `in_valid` during FLUSH/IDLE → no state change, no beats consumed, beat count unaffected.
